// File: rtl/corr_pair_scheduler_if.sv
// Bundle between the pair scheduler and its neighbours: snapshot buffer read port,
// correlation processor operand/result ports, covariance RAM write port and status.
interface corr_pair_scheduler_if #(
    parameter int unsigned DATA_WIDTH_BITS = 12,
    parameter int unsigned CH_W            = 2,
    parameter int unsigned SNAP_AW         = 6,
    parameter int unsigned PAIR_W          = 4
);
    localparam int unsigned RES_W = 2 * DATA_WIDTH_BITS + 1;

    logic                       i_start;

    logic                       o_rd_en;
    logic [SNAP_AW-1:0]         o_rd_addr;
    logic [CH_W-1:0]            o_rd_ch_x;
    logic [CH_W-1:0]            o_rd_ch_y;
    logic [DATA_WIDTH_BITS-1:0] i_rd_x_r;
    logic [DATA_WIDTH_BITS-1:0] i_rd_x_c;
    logic [DATA_WIDTH_BITS-1:0] i_rd_y_r;
    logic [DATA_WIDTH_BITS-1:0] i_rd_y_c;

    logic [DATA_WIDTH_BITS-1:0] o_x_r;
    logic [DATA_WIDTH_BITS-1:0] o_x_c;
    logic [DATA_WIDTH_BITS-1:0] o_y_r;
    logic [DATA_WIDTH_BITS-1:0] o_y_c;
    logic                       o_x_valid;
    logic                       o_y_valid;
    logic                       o_x_last;
    logic                       o_y_last;
    logic                       i_x_ready;
    logic                       i_y_ready;

    logic                       i_res_valid;
    logic [RES_W-1:0]           i_res_r;
    logic [RES_W-1:0]           i_res_c;

    logic                       o_wr_en;
    logic [PAIR_W-1:0]          o_wr_addr;
    logic [RES_W-1:0]           o_wr_r;
    logic [RES_W-1:0]           o_wr_c;

    logic                       o_busy;
    logic                       o_done;
    logic                       o_err;

    // Scheduler side
    modport master (
        input  i_start,
        output o_rd_en, o_rd_addr, o_rd_ch_x, o_rd_ch_y,
        input  i_rd_x_r, i_rd_x_c, i_rd_y_r, i_rd_y_c,
        output o_x_r, o_x_c, o_y_r, o_y_c, o_x_valid, o_y_valid, o_x_last, o_y_last,
        input  i_x_ready, i_y_ready,
        input  i_res_valid, i_res_r, i_res_c,
        output o_wr_en, o_wr_addr, o_wr_r, o_wr_c,
        output o_busy, o_done, o_err
    );

    // Environment side (buffer, processor, RAM, control)
    modport slave (
        output i_start,
        input  o_rd_en, o_rd_addr, o_rd_ch_x, o_rd_ch_y,
        output i_rd_x_r, i_rd_x_c, i_rd_y_r, i_rd_y_c,
        input  o_x_r, o_x_c, o_y_r, o_y_c, o_x_valid, o_y_valid, o_x_last, o_y_last,
        output i_x_ready, i_y_ready,
        output i_res_valid, i_res_r, i_res_c,
        input  o_wr_en, o_wr_addr, o_wr_r, o_wr_c,
        input  o_busy, o_done, o_err
    );
endinterface

// File: rtl/corr_pair_scheduler.sv
// Walks every channel pair (p, q) with p <= q, streams one snapshot of x = ch p and
// y = conj(ch q) into the correlation processor, and writes each result to the
// covariance RAM at the pair index.
module corr_pair_scheduler #(
    parameter int unsigned DATA_WIDTH_BITS = 12,
    parameter int unsigned NUM_CH          = 4,
    parameter int unsigned CH_W            = 2,
    parameter int unsigned SNAP_LEN        = 64,
    parameter int unsigned SNAP_AW         = 6,
    parameter int unsigned PAIR_W          = 4,
    parameter int unsigned TIMEOUT         = 255
) (
    input logic                   i_clk,
    input logic                   i_reset,
    corr_pair_scheduler_if.master bus
);
    localparam int unsigned DW      = DATA_WIDTH_BITS;
    localparam int unsigned RES_W   = 2 * DW + 1;
    localparam int unsigned TIMER_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [SNAP_AW-1:0] K_LAST   = SNAP_AW'(SNAP_LEN - 1);
    localparam logic [CH_W-1:0]    CH_LAST  = CH_W'(NUM_CH - 1);
    localparam logic [TIMER_W-1:0] TMO_LAST = TIMER_W'(TIMEOUT);
    localparam logic [DW-1:0]      S_MIN    = {1'b1, {(DW - 1){1'b0}}};
    localparam logic [DW-1:0]      S_MAX    = {1'b0, {(DW - 1){1'b1}}};

    typedef enum logic [2:0] {StIdle, StLoad, StSend, StWaitRes, StWrite} state_e;

    state_e             state_q, state_d;
    logic [SNAP_AW-1:0] k_q;
    logic [CH_W-1:0]    p_q, q_q;
    logic [PAIR_W-1:0]  pair_q;
    logic [TIMER_W-1:0] timer_q;
    // High in the cycle a read is outstanding; LOAD waits one cycle for the data
    logic               rd_pend_q;
    logic [DW-1:0]      x_r_q, x_c_q, y_r_q, y_c_q;
    logic [RES_W-1:0]   wr_r_q, wr_c_q;
    logic               done_q, err_q;

    logic               hs, k_last, pair_last, tmo_hit;
    logic [DW-1:0]      y_c_conj;

    assign hs        = (state_q == StSend) & bus.i_x_ready & bus.i_y_ready;
    assign k_last    = (k_q == K_LAST);
    assign pair_last = (p_q == CH_LAST) & (q_q == CH_LAST);
    assign tmo_hit   = (timer_q == TMO_LAST);
    // Negating the most negative value overflows, so clamp it to the positive max
    assign y_c_conj  = (bus.i_rd_y_c == S_MIN) ? S_MAX : -bus.i_rd_y_c;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (bus.i_start) state_d = StLoad;
            StLoad:    if (!rd_pend_q) state_d = StSend;
            StSend:    if (hs) state_d = k_last ? StWaitRes : StLoad;
            StWaitRes: begin
                if (bus.i_res_valid) begin
                    state_d = StWrite;
                end else if (tmo_hit) begin
                    state_d = StIdle;
                end
            end
            StWrite:   state_d = pair_last ? StIdle : StLoad;
            default:   state_d = StIdle;
        endcase
    end

    // Counters, operand/result registers and status flags
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            k_q       <= '0;
            p_q       <= '0;
            q_q       <= '0;
            pair_q    <= '0;
            timer_q   <= '0;
            rd_pend_q <= 1'b0;
            x_r_q     <= '0;
            x_c_q     <= '0;
            y_r_q     <= '0;
            y_c_q     <= '0;
            wr_r_q    <= '0;
            wr_c_q    <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            rd_pend_q <= 1'b0;
            done_q    <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.i_start) begin
                        k_q       <= '0;
                        p_q       <= '0;
                        q_q       <= '0;
                        pair_q    <= '0;
                        err_q     <= 1'b0;
                        rd_pend_q <= 1'b1;
                    end
                end
                StLoad: begin
                    if (!rd_pend_q) begin
                        x_r_q <= bus.i_rd_x_r;
                        x_c_q <= bus.i_rd_x_c;
                        y_r_q <= bus.i_rd_y_r;
                        y_c_q <= y_c_conj;
                    end
                end
                StSend: begin
                    if (hs) begin
                        if (k_last) begin
                            timer_q <= '0;
                        end else begin
                            k_q <= k_q + 1'b1;
                        end
                    end
                end
                StWaitRes: begin
                    if (bus.i_res_valid) begin
                        wr_r_q <= bus.i_res_r;
                        wr_c_q <= bus.i_res_c;
                    end else if (tmo_hit) begin
                        err_q <= 1'b1;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                StWrite: begin
                    if (pair_last) begin
                        done_q <= 1'b1;
                    end else begin
                        // Upper-triangle walk: q runs p..NUM_CH-1, then p advances
                        if (q_q == CH_LAST) begin
                            p_q <= p_q + 1'b1;
                            q_q <= p_q + 1'b1;
                        end else begin
                            q_q <= q_q + 1'b1;
                        end
                        pair_q    <= pair_q + 1'b1;
                        k_q       <= '0;
                        rd_pend_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs; the next read is issued in the same cycle as the handshake
    always_comb begin
        bus.o_rd_en   = rd_pend_q | (hs & ~k_last);
        bus.o_rd_addr = (hs & ~k_last) ? (k_q + 1'b1) : k_q;
        bus.o_rd_ch_x = p_q;
        bus.o_rd_ch_y = q_q;
        bus.o_x_r     = x_r_q;
        bus.o_x_c     = x_c_q;
        bus.o_y_r     = y_r_q;
        bus.o_y_c     = y_c_q;
        bus.o_x_valid = (state_q == StSend);
        bus.o_y_valid = (state_q == StSend);
        bus.o_x_last  = (state_q == StSend) & k_last;
        bus.o_y_last  = (state_q == StSend) & k_last;
        bus.o_wr_en   = (state_q == StWrite);
        bus.o_wr_addr = pair_q;
        bus.o_wr_r    = wr_r_q;
        bus.o_wr_c    = wr_c_q;
        bus.o_busy    = (state_q != StIdle);
        bus.o_done    = done_q;
        bus.o_err     = err_q;
    end
endmodule
